// File: rtl/pcs_tx_scr_gearbox.sv
// pcs_tx_scr_gearbox: scrambles the 64b payload (x^58+x^39+1) and packs 66b blocks into 64b words.
// Latency: an accepted block starts on data_o the next cycle; its tail leaves within two cycles.
// Backpressure: ready_o drops for one cycle in every 33 while the full residual buffer is flushed.
module pcs_tx_scr_gearbox #(
  parameter int          DATA_W     = 64,
  parameter int          HEAD_W     = 2,
  parameter logic [57:0] SCR_INIT   = 58'h3ff_ffff_ffff_ffff,
  parameter bit          SCR_BYPASS = 1'b0
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              head_v_i,
  input  logic [HEAD_W-1:0] sync_head_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  // scr_state[57] is the most recently scrambled bit, scr_state[0] the oldest of the 58 kept.
  logic [57:0]  scr_state;
  logic [63:0]  scr_raw;
  logic [63:0]  scr;
  logic [5:0]   seq;
  logic [63:0]  resid;
  logic [6:0]   shamt;
  logic [127:0] packed_w;

  // Parallel scrambler: bit i taps the scrambled bits 39 and 58 positions earlier in line order,
  // reaching into the stored state while those positions precede the current block.
  always_comb begin
    scr_raw = '0;
    for (int i = 0; i < 39; i++) begin
      scr_raw[i] = data_i[i] ^ scr_state[i+19] ^ scr_state[i];
    end
    for (int i = 39; i < 58; i++) begin
      scr_raw[i] = data_i[i] ^ scr_raw[i-39] ^ scr_state[i];
    end
    for (int i = 58; i < 64; i++) begin
      scr_raw[i] = data_i[i] ^ scr_raw[i-39] ^ scr_raw[i-58];
    end
  end

  // In bypass the payload goes out as-is, but the state still tracks what was sent.
  assign scr   = SCR_BYPASS ? data_i : scr_raw;
  assign shamt = {seq, 1'b0};

  // Place the new block above the 2*seq residual bits; bits of resid above its length are always zero.
  always_comb begin
    packed_w = ({62'b0, scr, sync_head_i} << shamt) | {64'b0, resid};
  end

  // Gearbox state: emit the low 64 bits, keep the rest; on the 33rd cycle flush the full residual.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      seq       <= 6'd0;
      ready_o   <= 1'b1;
      valid_o   <= 1'b0;
      data_o    <= '0;
      resid     <= '0;
      scr_state <= SCR_INIT;
    end else begin
      valid_o <= 1'b1;
      if (ready_o) begin
        data_o    <= packed_w[63:0];
        resid     <= packed_w[127:64];
        scr_state <= scr[63:6];
        seq       <= seq + 6'd1;
        ready_o   <= (seq != 6'd31);
      end else begin
        data_o  <= resid;
        resid   <= '0;
        seq     <= 6'd0;
        ready_o <= 1'b1;
      end
    end
  end

  // The encoder must present a block on every cycle it is being accepted.
  assert property (@(posedge clk) disable iff (!nreset) ready_o |-> head_v_i);

endmodule

// File: tb/tb_pcs_tx_scr_gearbox.sv
// Bench for pcs_tx_scr_gearbox: random blocks against a bit-serial scrambler and bit-queue gearbox model,
// plus a 64b->66b receive path with descrambler for round-trip recovery.
module tb_pcs_tx_scr_gearbox;

  logic        clk = 1'b0;
  logic        nreset;
  logic        head_v;
  logic [1:0]  sync;
  logic [63:0] data;
  logic        ready, valid;
  logic [63:0] dout;
  logic        b_ready, b_valid;
  logic [63:0] b_dout;

  always #5 clk = ~clk;

  pcs_tx_scr_gearbox dut (
    .clk(clk), .nreset(nreset), .head_v_i(head_v), .sync_head_i(sync), .data_i(data),
    .ready_o(ready), .valid_o(valid), .data_o(dout)
  );

  pcs_tx_scr_gearbox #(.SCR_BYPASS(1'b1)) dut_byp (
    .clk(clk), .nreset(nreset), .head_v_i(head_v), .sync_head_i(sync), .data_i(data),
    .ready_o(b_ready), .valid_o(b_valid), .data_o(b_dout)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc;
  int          rx_blocks;
  logic        tx_q[$];
  logic        rx_q[$];
  logic [65:0] sent_q[$];
  logic [57:0] tx_hist;   // tx_hist[j]: scrambled bit j+1 positions back on the line
  logic [57:0] rx_hist;

  function automatic logic [1:0] rand_sync();
    return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [63:0] rand_data();
    return {$urandom, $urandom};
  endfunction

  task automatic reset_model();
    tx_q.delete();
    rx_q.delete();
    sent_q.delete();
    tx_hist   = '1;
    rx_hist   = '0;
    cyc       = 0;
    rx_blocks = 0;
  endtask

  // Called #1 after a rising edge; leaves the DUT out of reset with the model cleared.
  task automatic do_reset();
    nreset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    head_v = 1'b1;
    reset_model();
    nreset = 1'b1;
  endtask

  // One clock: present a block, check ready/valid/data_o against the model, run the receive path.
  task automatic step(input logic [1:0] s, input logic [63:0] d);
    logic        exp_ready;
    logic [63:0] exp_word;
    logic        sb;
    logic [65:0] got;
    logic [65:0] exp_blk;
    exp_ready = (cyc % 33) != 32;
    n_vec++;
    if (ready !== exp_ready) begin
      n_err++;
      $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, ready, exp_ready);
    end
    sync = s;
    data = d;
    @(posedge clk);
    #1;
    if (exp_ready) begin
      tx_q.push_back(s[0]);
      tx_q.push_back(s[1]);
      for (int i = 0; i < 64; i++) begin
        sb      = d[i] ^ tx_hist[38] ^ tx_hist[57];
        tx_hist = {tx_hist[56:0], sb};
        tx_q.push_back(sb);
      end
      sent_q.push_back({d, s});
    end
    for (int i = 0; i < 64; i++) exp_word[i] = tx_q.pop_front();
    n_vec++;
    if (dout !== exp_word) begin
      n_err++;
      $display("FAIL data_o cyc=%0d got=%h exp=%h", cyc, dout, exp_word);
    end
    n_vec++;
    if (valid !== 1'b1) begin
      n_err++;
      $display("FAIL valid_o cyc=%0d got=%b exp=1", cyc, valid);
    end
    for (int i = 0; i < 64; i++) rx_q.push_back(dout[i]);
    while (rx_q.size() >= 66) begin
      got[0] = rx_q.pop_front();
      got[1] = rx_q.pop_front();
      for (int i = 0; i < 64; i++) begin
        sb         = rx_q.pop_front();
        got[2+i]   = sb ^ rx_hist[38] ^ rx_hist[57];
        rx_hist    = {rx_hist[56:0], sb};
      end
      exp_blk = (sent_q.size() > 0) ? sent_q.pop_front() : 66'bx;
      if (rx_blocks > 0) begin
        n_vec++;
        if (got !== exp_blk) begin
          n_err++;
          $display("FAIL round_trip blk=%0d got=%h exp=%h", rx_blocks, got, exp_blk);
        end
      end
      rx_blocks++;
    end
    cyc++;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sync   = 2'($urandom);
      data   = rand_data();
      head_v = 1'($urandom);
      @(posedge clk);
      #1;
      n_vec++;
      if (dout !== 64'h0 || valid !== 1'b0 || ready !== 1'b1) begin
        n_err++;
        $display("FAIL reset_state data_o=%h valid_o=%b ready_o=%b exp 0/0/1", dout, valid, ready);
      end
      n_vec++;
      if (b_dout !== 64'h0 || b_valid !== 1'b0 || b_ready !== 1'b1) begin
        n_err++;
        $display("FAIL reset_state_byp data_o=%h valid_o=%b ready_o=%b exp 0/0/1", b_dout, b_valid, b_ready);
      end
    end
    head_v = 1'b1;
    reset_model();
    nreset = 1'b1;
    n_vec++;
    if (valid !== 1'b0) begin
      n_err++;
      $display("FAIL valid_before_edge got=%b exp=0", valid);
    end
    step(rand_sync(), rand_data());
  endtask

  task automatic test_scr_vector();
    do_reset();
    step(2'b10, 64'h0);
    n_vec++;
    if (dout !== 64'h0fff_fe00_0000_0002) begin
      n_err++;
      $display("FAIL scr_vector got=%h exp=0fff_fe00_0000_0002", dout);
    end
    for (int k = 0; k < 40; k++) step(rand_sync(), rand_data());
  endtask

  task automatic test_bypass();
    logic [1:0]  s1;
    logic [63:0] d1;
    do_reset();
    step(2'b01, 64'h0123_4567_89ab_cdef);
    n_vec++;
    if (b_dout !== 64'h048d_159e_26af_37bd || b_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bypass_first got=%h valid=%b exp=048d_159e_26af_37bd/1", b_dout, b_valid);
    end
    s1 = rand_sync();
    d1 = rand_data();
    step(s1, d1);
    n_vec++;
    if (b_dout !== {d1[59:0], s1, 2'b00}) begin
      n_err++;
      $display("FAIL bypass_second got=%h exp=%h", b_dout, {d1[59:0], s1, 2'b00});
    end
  endtask

  task automatic test_cadence();
    int stalls;
    stalls = 0;
    do_reset();
    for (int k = 0; k < 330; k++) begin
      if (ready === 1'b0) stalls++;
      step(rand_sync(), rand_data());
    end
    n_vec++;
    if (stalls != 10) begin
      n_err++;
      $display("FAIL stall_count got=%0d exp=10", stalls);
    end
  endtask

  task automatic test_round_trip();
    do_reset();
    for (int k = 0; k < 33 * 1000; k++) step(rand_sync(), rand_data());
    n_vec++;
    if (rx_blocks != 32000) begin
      n_err++;
      $display("FAIL rx_block_count got=%0d exp=32000", rx_blocks);
    end
  endtask

  task automatic test_midstream_reset();
    do_reset();
    for (int k = 0; k < 17; k++) step(rand_sync(), rand_data());
    #3;
    nreset = 1'b0;
    #1;
    n_vec++;
    if (dout !== 64'h0 || valid !== 1'b0 || ready !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset data_o=%h valid_o=%b ready_o=%b exp 0/0/1", dout, valid, ready);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_model();
    nreset = 1'b1;
    step(2'b10, 64'h0);
    n_vec++;
    if (dout !== 64'h0fff_fe00_0000_0002) begin
      n_err++;
      $display("FAIL restart_vector got=%h exp=0fff_fe00_0000_0002", dout);
    end
    for (int k = 0; k < 70; k++) step(rand_sync(), rand_data());
  endtask

  initial begin
    nreset = 1'b0;
    head_v = 1'b1;
    sync   = 2'b00;
    data   = 64'h0;
    reset_model();
    test_reset();
    test_scr_vector();
    test_bypass();
    test_cadence();
    test_midstream_reset();
    test_round_trip();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
